// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue_if: bus bundle for the writeback queue.
// Carries the execute-side writeback request, the RF write port, the shared
// read-address/read-data paths used for forwarding, and occupancy status.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// in_valid is held by the producer until accepted, in_ready never waits on
// in_valid. The RF side has no backpressure other than rf_wr_ok.
interface rf_wb_queue_if #(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rf_wr_ok;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rf_rs;
  logic [DW-1:0] rf_rt;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  // Queue side
  modport slave (
    input  in_valid, in_addr, in_data, rf_wr_ok, rs_addr, rt_addr, rf_rs, rf_rt,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rs_fwd, rt_fwd,
    output count, full, empty
  );

  // Datapath / register-file side
  modport master (
    output in_valid, in_addr, in_data, rf_wr_ok, rs_addr, rt_addr, rf_rs, rf_rt,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rs_fwd, rt_fwd,
    input  count, full, empty
  );
endinterface

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: FIFO of pending register writebacks in front of the 8x16 RF.
// Drains one entry per cycle into the RF write port when rf_wr_ok is high and
// forwards the youngest pending value for each read address so readers never
// observe stale RF contents.
// Optional feature: define RF_WB_R0_ZERO_EN for RISC-V x0 semantics (writes
// to register 0 are accepted but dropped; reads of register 0 return 0).
module rf_wb_queue #(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic full_w, empty_w, accept_w, push_w, pop_w;
  logic [DW-1:0] rs_fwd_w, rt_fwd_w;

  assign full_w   = (count_q == CW'(DEPTH));
  assign empty_w  = (count_q == '0);
  // No push-through: a full queue refuses input even when it pops this cycle.
  assign accept_w = bus.in_valid && !full_w;
`ifdef RF_WB_R0_ZERO_EN
  // x0 writes complete the handshake but never occupy an entry.
  assign push_w   = accept_w && (bus.in_addr != '0);
`else
  assign push_w   = accept_w;
`endif
  // Input is never bypassed: only a resident head entry can be written.
  assign pop_w    = !empty_w && bus.rf_wr_ok;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_w && !pop_w)      count_d = count_q + 1'b1;
    else if (!push_w && pop_w) count_d = count_q - 1'b1;
  end

  // Queue storage, pointers and valid bits; reset discards all pending writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Push and pop never target the same slot (that needs full or empty).
      if (pop_w) vld_q[rd_ptr_q] <= 1'b0;
      if (push_w) begin
        addr_q[wr_ptr_q] <= bus.in_addr;
        data_q[wr_ptr_q] <= bus.in_data;
        vld_q[wr_ptr_q]  <= 1'b1;
      end
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins; the head
  // being written this cycle still counts as pending.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    rs_fwd_w = bus.rf_rs;
    rt_fwd_w = bus.rf_rt;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (vld_q[idx] && (addr_q[idx] == bus.rs_addr)) rs_fwd_w = data_q[idx];
      if (vld_q[idx] && (addr_q[idx] == bus.rt_addr)) rt_fwd_w = data_q[idx];
    end
`ifdef RF_WB_R0_ZERO_EN
    if (bus.rs_addr == '0) rs_fwd_w = '0;
    if (bus.rt_addr == '0) rt_fwd_w = '0;
`endif
  end

  assign bus.in_ready   = !full_w;
  assign bus.rf_wr_en   = pop_w;
  assign bus.rf_wr_addr = empty_w ? '0 : addr_q[rd_ptr_q];
  assign bus.rf_wr_data = empty_w ? '0 : data_q[rd_ptr_q];
  assign bus.rs_fwd     = rs_fwd_w;
  assign bus.rt_fwd     = rt_fwd_w;
  assign bus.count      = count_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
endmodule
